// File: rtl/elevator_disp_pkg.sv
// Shared types, segment encodings and digit helpers for the elevator floor display.
package elevator_disp_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned VAL_W = 7;

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    // Segments active-high, bit6=a ... bit0=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] bcd);
        logic [SEG_W-1:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Split 0..99 into tens/units with constant compares instead of a divider
    function automatic bcd_pair_t split_val(input logic [VAL_W-1:0] val);
        bcd_pair_t        d;
        logic [VAL_W-1:0] rem;
        d = '0;
        for (int unsigned i = 1; i <= 9; i++) begin
            if (val >= VAL_W'(10 * i)) begin
                d.tens = 4'(i);
            end
        end
        rem     = val - VAL_W'(d.tens) * VAL_W'(10);
        d.units = 4'(rem);
        return d;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running modulo-DIV counter with enable, synchronous clear and terminal-count pulse.
module disp_prescaler #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c_o
);

    localparam int unsigned    CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count ignores clr so callers may derive clr from it without a loop
    always_comb begin
        cnt_d  = cnt_q;
        tc_c_o = en_i && (cnt_q == LAST);
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/elevator_display_ctrl.sv
// Two-digit multiplexed floor indicator with move blink and arrival flash.
// Define DISP_LEADING_ZERO_EN to show a leading "0" instead of a blank tens digit.
module elevator_display_ctrl
    import elevator_disp_pkg::*;
#(
    parameter int unsigned NUM_FLOORS     = 3,
    parameter int unsigned FLOOR_W        = 7,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned ARRIVE_FLASHES = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               floor_vld,
    input  logic               moving,
    output logic [6:0]         seg,
    output logic [1:0]         dig_en,
    output logic               err
);

    localparam int unsigned      CMP_W        = FLOOR_W + 1;
    localparam logic [CMP_W-1:0] NUM_FLOORS_C = CMP_W'(NUM_FLOORS);
    localparam int unsigned      FLASH_W      = $clog2(ARRIVE_FLASHES + 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(ARRIVE_FLASHES);

    disp_state_e        state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               err_q, err_d;
    logic               phase_q, phase_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               scan_sel_q, scan_sel_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [1:0]         dig_en_q, dig_en_d;

    logic               floor_ok_c;
    logic               blink_tc_c;
    logic               scan_tc_c;
    logic               blink_en_c;
    logic               state_entry_c;
    logic               disp_on_c;
    logic [VAL_W-1:0]   val_c;
    bcd_pair_t          digits_c;
    logic [SEG_W-1:0]   tens_seg_c;
    logic [SEG_W-1:0]   digit_seg_c;

    assign blink_en_c = (state_q != STEADY);

    disp_prescaler #(.DIV(BLINK_DIV)) u_blink (
        .clk_i  (clock),
        .rst_i  (reset),
        .clr_i  (state_entry_c),
        .en_i   (blink_en_c),
        .tc_c_o (blink_tc_c)
    );

    disp_prescaler #(.DIV(SCAN_DIV)) u_scan (
        .clk_i  (clock),
        .rst_i  (reset),
        .clr_i  (1'b0),
        .en_i   (1'b1),
        .tc_c_o (scan_tc_c)
    );

    // Floor latch: out-of-range index keeps the last good floor and raises err
    always_comb begin
        floor_d    = floor_q;
        err_d      = err_q;
        floor_ok_c = ({1'b0, floor} < NUM_FLOORS_C);
        if (floor_vld) begin
            if (floor_ok_c) begin
                floor_d = floor;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    // Arrival flash counts each off->on phase edge; moving always wins
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        phase_d     = phase_q;
        case (state_q)
            STEADY: begin
                if (moving) state_d = MOVE;
            end
            MOVE: begin
                if (!moving) begin
                    state_d     = ARRIVE;
                    flash_cnt_d = '0;
                end
            end
            ARRIVE: begin
                if (moving) begin
                    state_d = MOVE;
                end else if (blink_tc_c && !phase_q) begin
                    if (flash_cnt_q + FLASH_W'(1) == FLASH_LAST) begin
                        state_d = STEADY;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                    end
                end
            end
            default: state_d = STEADY;
        endcase

        state_entry_c = (state_d != state_q);
        if (state_entry_c) begin
            phase_d = 1'b1;
        end else if (blink_tc_c) begin
            phase_d = !phase_q;
        end
    end

    // Digit decode and output staging
    always_comb begin
        val_c      = VAL_W'(floor_q) + VAL_W'(1);
        digits_c   = split_val(val_c);
`ifdef DISP_LEADING_ZERO_EN
        tens_seg_c = bcd_to_seg(digits_c.tens);
`else
        tens_seg_c = (digits_c.tens == 4'd0) ? SEG_BLANK : bcd_to_seg(digits_c.tens);
`endif
        digit_seg_c = scan_sel_q ? tens_seg_c : bcd_to_seg(digits_c.units);
        disp_on_c   = (state_q == STEADY) || phase_q;
        seg_d       = disp_on_c ? digit_seg_c : SEG_BLANK;
        dig_en_d    = scan_sel_q ? 2'b10 : 2'b01;
        scan_sel_d  = scan_tc_c ? !scan_sel_q : scan_sel_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= STEADY;
            floor_q     <= '0;
            err_q       <= 1'b0;
            phase_q     <= 1'b1;
            flash_cnt_q <= '0;
            scan_sel_q  <= 1'b0;
            seg_q       <= SEG_1;
            dig_en_q    <= 2'b01;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            err_q       <= err_d;
            phase_q     <= phase_d;
            flash_cnt_q <= flash_cnt_d;
            scan_sel_q  <= scan_sel_d;
            seg_q       <= seg_d;
            dig_en_q    <= dig_en_d;
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;
    assign err    = err_q;

endmodule

// File: tb/tb_elevator_display_ctrl.sv
// Directed bench for elevator_display_ctrl with 12 floors and short dividers.
module tb_elevator_display_ctrl;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S5 = 7'b1011011;
`ifdef DISP_LEADING_ZERO_EN
    localparam logic [6:0] TZ = S0;
`else
    localparam logic [6:0] TZ = 7'b0000000;
`endif

    logic       clock;
    logic       reset;
    logic [6:0] floor;
    logic       floor_vld;
    logic       moving;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       err;

    int cyc;
    int n_chk;
    int n_pass;

    elevator_display_ctrl #(
        .NUM_FLOORS     (12),
        .FLOOR_W        (7),
        .BLINK_DIV      (4),
        .SCAN_DIV       (2),
        .ARRIVE_FLASHES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .floor     (floor),
        .floor_vld (floor_vld),
        .moving    (moving),
        .seg       (seg),
        .dig_en    (dig_en),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Slot after cycle k: units for k=0..2, then tens/units alternate every two cycles
    task automatic check_disp(input string tag, input logic [6:0] tens_pat,
                              input logic [6:0] units_pat, input logic on);
        logic       tens_slot;
        logic [1:0] exp_dig;
        logic [6:0] exp_seg;
        tens_slot = (cyc >= 1) && ((((cyc - 1) / 2) % 2) == 1);
        exp_dig   = tens_slot ? 2'b10 : 2'b01;
        exp_seg   = on ? (tens_slot ? tens_pat : units_pat) : 7'b0000000;
        chk({tag, "_dig"}, 32'(dig_en), 32'(exp_dig));
        chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        reset     = 1'b1;
        floor     = '0;
        floor_vld = 1'b0;
        moving    = 1'b0;
        cyc       = 0;
        n_chk     = 0;
        n_pass    = 0;

        repeat (3) tick();
        reset = 1'b0;
        cyc   = 0;
        chk("rst_seg", 32'(seg), 32'(S1));
        chk("rst_dig", 32'(dig_en), 32'(2'b01));
        chk("rst_err", 32'(err), 32'(1'b0));
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_disp("idle", TZ, S1, 1'b1);
        end

        // Highest legal floor index shows "12"
        floor = 7'd11; floor_vld = 1'b1;
        tick();
        floor_vld = 1'b0;
        chk("f11_err", 32'(err), 32'(1'b0));
        check_disp("f11_lat", TZ, S1, 1'b1);
        for (int k = 7; k <= 10; k++) begin
            tick();
            check_disp("f11", S1, S2, 1'b1);
        end

        // First illegal index: sticky err, display frozen
        floor = 7'd12; floor_vld = 1'b1;
        tick();
        floor_vld = 1'b0;
        chk("f12_err", 32'(err), 32'(1'b1));
        check_disp("f12", S1, S2, 1'b1);
        for (int k = 12; k <= 13; k++) begin
            tick();
            chk("f12_err_hold", 32'(err), 32'(1'b1));
            check_disp("f12_hold", S1, S2, 1'b1);
        end

        floor = 7'd4; floor_vld = 1'b1;
        tick();
        floor_vld = 1'b0;
        chk("f4_err", 32'(err), 32'(1'b0));
        check_disp("f4_lat", S1, S2, 1'b1);
        for (int k = 15; k <= 17; k++) begin
            tick();
            check_disp("f4", TZ, S5, 1'b1);
        end

        // Move for 20 cycles together with a new floor, then arrival flashes
        floor = 7'd11; floor_vld = 1'b1; moving = 1'b1;
        tick();
        floor_vld = 1'b0;
        check_disp("mv_start", TZ, S5, 1'b1);
        for (int k = 19; k <= 62; k++) begin
            logic on;
            tick();
            on = !((k >= 23 && k <= 26) || (k >= 31 && k <= 34) ||
                   (k >= 43 && k <= 46) || (k >= 51 && k <= 54));
            check_disp("move_arrive", S1, S2, on);
            if (k == 37) moving = 1'b0;
        end

        // Re-enter MOVE after one arrival flash; blink restarts visible
        moving = 1'b1;
        for (int k = 63; k <= 89; k++) begin
            logic on;
            tick();
            on = !((k >= 72 && k <= 75) || (k >= 82 && k <= 85));
            check_disp("rearm", S1, S2, on);
            if (k == 66) moving = 1'b0;
            if (k == 76) moving = 1'b1;
            if (k == 88) begin
                floor = 7'd20; floor_vld = 1'b1;
            end
            if (k == 89) begin
                floor_vld = 1'b0;
                chk("f20_err", 32'(err), 32'(1'b1));
            end
        end

        // Reset while moving overrides everything
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        moving = 1'b0;
        cyc    = 0;
        chk("mrst_seg", 32'(seg), 32'(S1));
        chk("mrst_dig", 32'(dig_en), 32'(2'b01));
        chk("mrst_err", 32'(err), 32'(1'b0));
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_disp("post_rst", TZ, S1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
